// File: rtl/pe_tree_acc.sv
// pe_tree_acc: lane-wise integer x fixed-point products reduced by a pipelined
// saturating adder tree, then accumulated across beats into a packet result.
module pe_tree_acc #(
    parameter int N_IN = 8,
    parameter int IN_W = 2,
    parameter int W    = 16,
    parameter int FRAC = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 clr,
    input  logic                 in_valid,
    input  logic                 in_last,
    input  logic [N_IN*IN_W-1:0] in_vec,
    input  logic [N_IN*W-1:0]    w_vec,
    output logic [W-1:0]         out,
    output logic                 out_valid,
    output logic                 sat
);
    localparam int L  = $clog2(N_IN);
    localparam int PW = W + IN_W + 1;
    localparam logic signed [W-1:0] MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};

    if ((1 << L) != N_IN || N_IN < 2 || FRAC >= W) begin : g_bad_param
        $error("pe_tree_acc: N_IN must be a power of two >= 2 and FRAC < W");
    end

    // Integer times Q-format keeps the same binary point, so no shift is needed.
    function automatic logic [W:0] smul(input logic [IN_W-1:0] a, input logic signed [W-1:0] w);
        logic signed [PW-1:0] p;
        p = PW'($signed({1'b0, a})) * PW'(w);
        return (&p[PW-1:W-1] || ~|p[PW-1:W-1]) ? {1'b0, p[W-1:0]} : {1'b1, p[PW-1] ? MIN : MAX};
    endfunction

    function automatic logic [W:0] sadd(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
        logic signed [W:0] s;
        s = {a[W-1], a} + {b[W-1], b};
        return (s[W] ^ s[W-1]) ? {1'b1, s[W] ? MIN : MAX} : {1'b0, s[W-1:0]};
    endfunction

    logic [N_IN*IN_W-1:0] s0_vec;
    logic                 s0_v, s0_last;
    // Heap-ordered tree: node 1 is the root, leaves N_IN..2*N_IN-1 hold the products.
    logic signed [W-1:0]  nd   [1:2*N_IN-1];
    logic                 ns   [1:2*N_IN-1];
    logic signed [W-1:0]  nd_n [1:2*N_IN-1];
    logic                 ns_n [1:2*N_IN-1];
    logic [L:0]           lv, ll;
    logic signed [W-1:0]  acc;
    logic                 acc_sat;
    logic [W:0]           acc_n;
    logic                 tot_sat;

    always_comb begin
        for (int k = 0; k < N_IN; k++)
            {ns_n[N_IN+k], nd_n[N_IN+k]} = smul(s0_vec[k*IN_W +: IN_W], w_vec[k*W +: W]);
        for (int i = 1; i < N_IN; i++) begin
            {ns_n[i], nd_n[i]} = sadd(nd[2*i], nd[2*i+1]);
            ns_n[i] = ns_n[i] | ns[2*i] | ns[2*i+1];
        end
        acc_n   = sadd(acc, nd[1]);
        tot_sat = acc_sat | ns[1] | acc_n[W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_vec    <= '0;
            s0_v      <= 1'b0;
            s0_last   <= 1'b0;
            for (int i = 1; i < 2*N_IN; i++) begin
                nd[i] <= '0;
                ns[i] <= 1'b0;
            end
            lv        <= '0;
            ll        <= '0;
            acc       <= '0;
            acc_sat   <= 1'b0;
            out       <= '0;
            out_valid <= 1'b0;
            sat       <= 1'b0;
        end else if (clr) begin
            s0_vec    <= '0;
            s0_v      <= 1'b0;
            s0_last   <= 1'b0;
            for (int i = 1; i < 2*N_IN; i++) begin
                nd[i] <= '0;
                ns[i] <= 1'b0;
            end
            lv        <= '0;
            ll        <= '0;
            acc       <= '0;
            acc_sat   <= 1'b0;
            out       <= '0;
            out_valid <= 1'b0;
            sat       <= 1'b0;
        end else if (en) begin
            s0_vec    <= in_vec;
            s0_v      <= in_valid;
            s0_last   <= in_valid & in_last;
            nd        <= nd_n;
            ns        <= ns_n;
            lv        <= {lv[L-1:0], s0_v};
            ll        <= {ll[L-1:0], s0_last};
            out_valid <= lv[L] & ll[L];
            if (lv[L] && ll[L]) begin
                out     <= acc_n[W-1:0];
                sat     <= tot_sat;
                acc     <= '0;
                acc_sat <= 1'b0;
            end else if (lv[L]) begin
                acc     <= acc_n[W-1:0];
                acc_sat <= tot_sat;
            end
        end
    end
endmodule

// File: tb/tb_pe_tree_acc.sv
// tb_pe_tree_acc: vector table plus corner sequences, scoreboard-checked at out_valid.
module tb_pe_tree_acc;
    logic         clk = 0, rst_n = 0, en = 1, clr = 0, in_valid = 0, in_last = 0;
    logic [15:0]  in_vec = '0;
    logic [127:0] w_vec = '0;
    logic [15:0]  out;
    logic         out_valid, sat;
    logic         last_en = 0;
    int           errors = 0, checks = 0, c;

    typedef struct {logic [15:0] o; logic s;} exp_t;
    typedef struct {logic [15:0] iv; logic [127:0] w; logic [15:0] o; logic s;} vec_t;
    exp_t sb[$];
    exp_t e;
    localparam int NV = 9;
    vec_t tbl[NV];

    always #5 clk = ~clk;

    pe_tree_acc dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .in_valid(in_valid), .in_last(in_last),
        .in_vec(in_vec), .w_vec(w_vec), .out(out), .out_valid(out_valid), .sat(sat)
    );

    function automatic logic [127:0] rep_w(input logic [15:0] x);
        return {8{x}};
    endfunction

    function automatic logic [15:0] rep_i(input logic [1:0] x);
        return {8{x}};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat(input logic [15:0] iv, input logic last);
        in_valid = 1;
        in_vec   = iv;
        in_last  = last;
        tick();
        in_valid = 0;
        in_last  = 0;
    endtask

    task automatic wait_ov(output int cnt);
        cnt = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (out_valid) begin
                cnt = k;
                break;
            end
        end
    endtask

    task automatic expect_out(input logic [15:0] o, input logic s);
        exp_t x;
        x.o = o;
        x.s = s;
        sb.push_back(x);
    endtask

    always @(posedge clk) last_en <= en;

    // A new result is one seen after an enabled edge; held pulses are not recounted.
    always @(negedge clk) begin
        if (rst_n && out_valid && last_en) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: got out=%h sat=%b want no pulse", out, sat);
            end else begin
                e = sb.pop_front();
                chk("out", 32'(out), 32'(e.o));
                chk("sat", 32'(sat), 32'(e.s));
            end
        end
    end

    initial begin
        tbl[0] = '{rep_i(2'd1), rep_w(16'h0080), 16'h0400, 1'b0};
        tbl[1] = '{rep_i(2'd2), rep_w(16'hFF80), 16'hF800, 1'b0};
        tbl[2] = '{rep_i(2'd3), rep_w(16'h8000), 16'h8000, 1'b1};
        tbl[3] = '{rep_i(2'd0), rep_w(16'h7FFF), 16'h0000, 1'b0};
        tbl[4] = '{rep_i(2'd3), rep_w(16'h7FFF), 16'h7FFF, 1'b1};
        tbl[5] = '{rep_i(2'd1), rep_w(16'h1000), 16'h7FFF, 1'b1};
        tbl[6] = '{16'hE4E4, rep_w(16'h0100), 16'h0C00, 1'b0};
        tbl[7] = '{rep_i(2'd1), {4{32'hFF80_0080}}, 16'h0000, 1'b0};
        tbl[8] = '{rep_i(2'd3), rep_w(16'h0001), 16'h0018, 1'b0};

        w_vec = rep_w(16'h0080);
        tick(2);
        chk("reset_out", 32'(out), 0);
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_sat", 32'(sat), 0);
        rst_n = 1;
        tick();

        // single beat 8.0, latency 6
        expect_out(16'h0400, 1'b0);
        beat(16'h5555, 1'b1);
        wait_ov(c);
        chk("latency", 32'(1 + c), 6);
        tick();
        chk("pulse_one_beat", 32'(out_valid), 0);
        chk("out_hold", 32'(out), 32'h0400);

        // three-beat packet, only one pulse
        expect_out(16'h0C00, 1'b0);
        beat(16'h5555, 1'b0);
        beat(16'h5555, 1'b0);
        beat(16'h5555, 1'b1);
        tick(10);

        // en low 3 cycles while in flight
        expect_out(16'h0400, 1'b0);
        beat(16'h5555, 1'b1);
        tick();
        en = 0;
        tick(3);
        en = 1;
        wait_ov(c);
        chk("latency_en_low", 32'(5 + c), 9);
        en = 0;
        tick(2);
        chk("pulse_held_en_low", 32'(out_valid), 1);
        chk("out_held_en_low", 32'(out), 32'h0400);
        en = 1;
        tick();
        chk("pulse_drops", 32'(out_valid), 0);

        // back-to-back single-beat packets, weights lag inputs by a cycle
        for (int i = 0; i <= NV; i++) begin
            in_valid = (i < NV);
            in_last  = (i < NV);
            if (i < NV) begin
                in_vec = tbl[i].iv;
                expect_out(tbl[i].o, tbl[i].s);
            end
            if (i > 0) w_vec = tbl[i-1].w;
            tick();
        end
        in_valid = 0;
        in_last  = 0;
        tick(10);
        w_vec = rep_w(16'h0080);

        // clr mid-packet discards partial sum
        beat(16'h5555, 1'b0);
        beat(16'h5555, 1'b0);
        clr = 1;
        tick();
        clr = 0;
        chk("clr_out", 32'(out), 0);
        expect_out(16'h0400, 1'b0);
        beat(16'h5555, 1'b1);
        tick(10);

        // async reset mid-packet
        chk("out_before_rst", 32'(out), 32'h0400);
        beat(16'h5555, 1'b0);
        beat(16'h5555, 1'b0);
        #2 rst_n = 0;
        #1;
        chk("async_rst_out", 32'(out), 0);
        chk("async_rst_out_valid", 32'(out_valid), 0);
        tick();
        rst_n = 1;
        tick();
        expect_out(16'h0400, 1'b0);
        beat(16'h5555, 1'b1);
        tick(10);

        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
